// File: rtl/completion_buffer.sv
// In-order completion buffer: dual-issue allocate, out-of-order finish, and up to
// two oldest-first retirements per cycle that drive ARF update strobes.

module cb_entry (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       allocSet,
  input  logic       allocWr,
  input  logic [4:0] allocDest,
  input  logic       finSet,
  input  logic       retire,
  output logic       valid,
  output logic       finished,
  output logic       wr,
  output logic [4:0] dest
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      finished <= 1'b0;
      wr       <= 1'b0;
      dest     <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
      finished <= 1'b0;
    end else if (allocSet) begin
      valid    <= 1'b1;
      finished <= 1'b0;
      wr       <= allocWr;
      dest     <= allocDest;
    end else if (retire) begin
      valid    <= 1'b0;
      finished <= 1'b0;
    end else if (finSet && valid) begin
      finished <= 1'b1;
    end
  end
endmodule

module completion_buffer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en_A,
  input  logic             alloc_en_B,
  input  logic             alloc_wr_A,
  input  logic             alloc_wr_B,
  input  logic [4:0]       alloc_dest_A,
  input  logic [4:0]       alloc_dest_B,
  output logic [IDX_W-1:0] alloc_tag_A,
  output logic [IDX_W-1:0] alloc_tag_B,
  output logic             alloc_stall,
  input  logic             fin_en_A,
  input  logic             fin_en_B,
  input  logic [IDX_W-1:0] fin_tag_A,
  input  logic [IDX_W-1:0] fin_tag_B,
  input  logic             flush,
  output logic             updateEnA,
  output logic             updateEnB,
  output logic [4:0]       updateAddrA,
  output logic [4:0]       updateAddrB,
  output logic [IDX_W:0]   count,
  output logic             empty,
  output logic             full
);
  logic [DEPTH-1:0]      valid, finished, wr;
  logic [DEPTH-1:0][4:0] dest;
  logic [DEPTH-1:0]      allocSet, finSet, retire;
  logic [IDX_W-1:0]      head, tail, headP1;
  logic [IDX_W:0]        nReq, space;
  logic                  accA, accB, r0, r1;

  // Space check uses registered count only, so same-cycle retires never free room.
  assign nReq        = (IDX_W+1)'(alloc_en_A) + (IDX_W+1)'(alloc_en_B);
  assign space       = (IDX_W+1)'(DEPTH) - count;
  assign alloc_stall = flush | (nReq > space);
  assign accA        = alloc_en_A & ~alloc_stall;
  assign accB        = alloc_en_B & ~alloc_stall;
  assign alloc_tag_A = tail;
  assign alloc_tag_B = tail + IDX_W'(alloc_en_A);

  assign headP1 = head + IDX_W'(1);
  assign r0     = valid[head] & finished[head];
  assign r1     = r0 & valid[headP1] & finished[headP1];

  assign empty = (count == '0);
  assign full  = (count == (IDX_W+1)'(DEPTH));

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : gEnt
      assign allocSet[i] = (accA && alloc_tag_A == IDX_W'(i)) ||
                           (accB && alloc_tag_B == IDX_W'(i));
      assign finSet[i]   = (fin_en_A && fin_tag_A == IDX_W'(i)) ||
                           (fin_en_B && fin_tag_B == IDX_W'(i));
      assign retire[i]   = (r0 && head == IDX_W'(i)) || (r1 && headP1 == IDX_W'(i));

      cb_entry uEnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .allocSet  (allocSet[i]),
        .allocWr   (accA && alloc_tag_A == IDX_W'(i) ? alloc_wr_A : alloc_wr_B),
        .allocDest (accA && alloc_tag_A == IDX_W'(i) ? alloc_dest_A : alloc_dest_B),
        .finSet    (finSet[i]),
        .retire    (retire[i]),
        .valid     (valid[i]),
        .finished  (finished[i]),
        .wr        (wr[i]),
        .dest      (dest[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      updateEnA   <= 1'b0;
      updateEnB   <= 1'b0;
      updateAddrA <= '0;
      updateAddrB <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      updateEnA <= 1'b0;
      updateEnB <= 1'b0;
    end else begin
      head        <= head + IDX_W'(r0) + IDX_W'(r1);
      tail        <= tail + IDX_W'(accA) + IDX_W'(accB);
      count       <= count + (IDX_W+1)'(accA) + (IDX_W+1)'(accB)
                           - (IDX_W+1)'(r0) - (IDX_W+1)'(r1);
      updateEnA   <= r0 & wr[head];
      updateEnB   <= r1 & wr[headP1];
      updateAddrA <= dest[head];
      updateAddrB <= dest[headP1];
    end
  end
endmodule

// File: tb/tb_completion_buffer.sv
// Directed bench for completion_buffer: reset, dual alloc/retire, full/stall,
// wrap-around, non-GPR retire and flush, all against hand-computed values.

module tb_completion_buffer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       alloc_en_A, alloc_en_B, alloc_wr_A, alloc_wr_B;
  logic [4:0] alloc_dest_A, alloc_dest_B;
  logic [2:0] alloc_tag_A, alloc_tag_B;
  logic       alloc_stall;
  logic       fin_en_A, fin_en_B;
  logic [2:0] fin_tag_A, fin_tag_B;
  logic       flush;
  logic       updateEnA, updateEnB;
  logic [4:0] updateAddrA, updateAddrB;
  logic [3:0] count;
  logic       empty, full;

  int nTests = 0;
  int nFail  = 0;

  completion_buffer #(.DEPTH(8), .IDX_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_en_A(alloc_en_A), .alloc_en_B(alloc_en_B),
    .alloc_wr_A(alloc_wr_A), .alloc_wr_B(alloc_wr_B),
    .alloc_dest_A(alloc_dest_A), .alloc_dest_B(alloc_dest_B),
    .alloc_tag_A(alloc_tag_A), .alloc_tag_B(alloc_tag_B),
    .alloc_stall(alloc_stall),
    .fin_en_A(fin_en_A), .fin_en_B(fin_en_B),
    .fin_tag_A(fin_tag_A), .fin_tag_B(fin_tag_B),
    .flush(flush),
    .updateEnA(updateEnA), .updateEnB(updateEnB),
    .updateAddrA(updateAddrA), .updateAddrB(updateAddrB),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clrIn();
    alloc_en_A = 0; alloc_en_B = 0; alloc_wr_A = 0; alloc_wr_B = 0;
    alloc_dest_A = 0; alloc_dest_B = 0;
    fin_en_A = 0; fin_en_B = 0; fin_tag_A = 0; fin_tag_B = 0;
    flush = 0;
  endtask

  task automatic allocA(input logic wr, input logic [4:0] d);
    alloc_en_A = 1; alloc_wr_A = wr; alloc_dest_A = d;
  endtask

  task automatic allocB(input logic wr, input logic [4:0] d);
    alloc_en_B = 1; alloc_wr_B = wr; alloc_dest_B = d;
  endtask

  initial begin
    rst_n = 0;
    clrIn();
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_updA", updateEnA, 0);
    chk("rst_updB", updateEnB, 0);
    chk("rst_tagA", alloc_tag_A, 0);
    chk("rst_stall", alloc_stall, 0);
    @(negedge clk);
    rst_n = 1;

    // dual alloc, out-of-order finish, same-cycle dual retire
    allocA(1, 3); allocB(1, 7);
    #1;
    chk("dual_tagA", alloc_tag_A, 0);
    chk("dual_tagB", alloc_tag_B, 1);
    chk("dual_stall", alloc_stall, 0);
    step(); clrIn();
    chk("dual_count", count, 2);
    fin_en_A = 1; fin_tag_A = 1;
    step(); clrIn();
    chk("fin1_noupd", updateEnA, 0);
    step();
    chk("fin1_noupd2", updateEnA, 0);
    fin_en_A = 1; fin_tag_A = 0;
    step(); clrIn();
    chk("fin0_E_noupd", updateEnA, 0);
    step();
    chk("ret_updA", updateEnA, 1);
    chk("ret_addrA", updateAddrA, 3);
    chk("ret_updB", updateEnB, 1);
    chk("ret_addrB", updateAddrB, 7);
    chk("ret_count", count, 0);
    step();
    chk("ret_pulseA", updateEnA, 0);
    chk("ret_pulseB", updateEnB, 0);

    // fill from tail=2; dual at count 7 must stall atomically
    for (int i = 0; i < 7; i++) begin
      allocA(1, 5'(i));
      step();
    end
    clrIn();
    chk("fill7_count", count, 7);
    allocA(1, 20); allocB(1, 21);
    #1;
    chk("c7_dual_stall", alloc_stall, 1);
    chk("c7_tagA", alloc_tag_A, 1);
    step(); clrIn();
    chk("c7_count", count, 7);
    chk("c7_tail", alloc_tag_A, 1);
    allocA(1, 22);
    step(); clrIn();
    chk("full_count", count, 8);
    chk("full_flag", full, 1);
    allocA(1, 23);
    #1;
    chk("full_stall", alloc_stall, 1);
    step(); clrIn();
    chk("full_hold", count, 8);

    // asynchronous reset mid-traffic
    #2;
    rst_n = 0;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_full", full, 0);
    chk("mrst_updA", updateEnA, 0);
    chk("mrst_updB", updateEnB, 0);
    chk("mrst_tagA", alloc_tag_A, 0);
    @(negedge clk);
    rst_n = 1;

    // wrap: 12 single-issue round trips, dest = tag+1
    for (int i = 0; i < 12; i++) begin
      allocA(1, 5'((i % 8) + 1));
      #1;
      chk("wrap_tag", alloc_tag_A, i % 8);
      step(); clrIn();
      fin_en_A = 1; fin_tag_A = 3'(i % 8);
      step(); clrIn();
      step();
      chk("wrap_upd", updateEnA, 1);
      chk("wrap_addr", updateAddrA, (i % 8) + 1);
      chk("wrap_count", count, 0);
    end

    // flush with 5 entries (tags 4..0), three younger ones finished
    allocA(1, 10); allocB(1, 11);
    step();
    allocA(1, 12); allocB(1, 13);
    step(); clrIn();
    allocA(1, 14);
    step(); clrIn();
    fin_en_A = 1; fin_tag_A = 5; fin_en_B = 1; fin_tag_B = 6;
    step(); clrIn();
    fin_en_A = 1; fin_tag_A = 7;
    step(); clrIn();
    chk("pre_flush_count", count, 5);
    chk("pre_flush_upd", updateEnA, 0);
    flush = 1; allocA(1, 15);
    #1;
    chk("flush_stall", alloc_stall, 1);
    step(); clrIn();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_updA", updateEnA, 0);
    chk("flush_updB", updateEnB, 0);
    step();
    chk("flush_updA2", updateEnA, 0);

    // non-GPR older entry retires silently alongside GPR entry
    allocA(0, 5); allocB(1, 9);
    #1;
    chk("ngpr_tagA", alloc_tag_A, 0);
    chk("ngpr_tagB", alloc_tag_B, 1);
    step(); clrIn();
    chk("ngpr_count", count, 2);
    fin_en_A = 1; fin_tag_A = 0; fin_en_B = 1; fin_tag_B = 1;
    step(); clrIn();
    chk("ngpr_E_upd", updateEnB, 0);
    step();
    chk("ngpr_updA", updateEnA, 0);
    chk("ngpr_updB", updateEnB, 1);
    chk("ngpr_addrB", updateAddrB, 9);
    chk("ngpr_count0", count, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
